data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder that services the load/store requests the pipelined datapath issues from its MEM stage (MemRead, MemWrite, ALU-result address, store data, DataWidth). It holds byte-addressed storage and performs word/half/byte accesses with configurable access latency. It drives a combinational Busy so the hazard logic can freeze the pipeline until the access completes. Misaligned, out-of-range and conflicting requests are reported on AddrError.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: wait cycles between acceptance and completion; legal range 1..15.

- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request from EX/MEM register.
- MemWrite  in  1  store request from EX/MEM register.
- Address  in  32  byte address (ALU result).
- WriteData  in  32  store data; only the low byte/half is used for narrow stores.
- DataWidth  in  2  00 word, 01 half (sign-extended), 10 byte (sign-extended), 11 illegal.
- ReadData  out  32  load result; valid while Done=1.
- Busy  out  1  combinational stall request to the hazard detection unit.
- Done  out  1  one-cycle completion pulse.
- AddrError  out  1  set with Done when the request was rejected.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: a request is MemRead|MemWrite. On a request, the block latches Address, WriteData, DataWidth and the kind (read/write), loads the wait counter with LATENCY-1, and moves to WAIT.
- WAIT: the counter decrements each cycle. At count 0 the block moves to DONE. A store commits to memory on this WAIT->DONE edge. A load registers ReadData on the same edge.
- DONE: Done=1 for exactly one cycle. Inputs are ignored in this state because the stalled pipeline still presents the same request. The FSM always returns to IDLE.
- Error check is made at acceptance. A request is rejected when any of these holds:
  - MemRead and MemWrite are both asserted;
  - DataWidth=11;
  - the access is misaligned: a half with Address[0]=1, or a word with Address[1:0]≠00;
  - Address[31:2] ≥ DEPTH_WORDS.
- A rejected request still passes through WAIT and DONE. In its DONE cycle AddrError=1 and ReadData=0. No memory write occurs.
- Byte lanes are little-endian; lane k is bits [8k+7:8k]:
  - a byte access uses lane Address[1:0];
  - a half access uses lanes {Address[1],1} and {Address[1],0};
  - loads sign-extend narrow data to 32 bits;
  - stores modify only the addressed lanes.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, ReadData=0, Done=0, AddrError=0. Busy=0 while in reset.
- Busy = (state≠IDLE) & (state≠DONE), OR (state==IDLE & request). Busy is high from the acceptance cycle through the last WAIT cycle and low in DONE, so the pipeline advances with ReadData valid.
- For a request first seen in cycle 0:
  - Busy is high in cycles 0..LATENCY;
  - Done, ReadData and AddrError are valid in cycle LATENCY+1;
  - the earliest next acceptance is cycle LATENCY+2.
- Back-to-back requests get no extra bubble beyond the DONE cycle.
- Reset asserted mid-operation returns the FSM to IDLE immediately:
  - a store still in WAIT is dropped and memory is unchanged;
  - a store already committed stays committed.
- Done, ReadData and AddrError are registered. Busy is the only combinational output.

## Structure
- Package mem_pkg holds:
  - the DataWidth encodings (DW_WORD, DW_HALF, DW_BYTE, DW_ILLEGAL);
  - the FSM state encoding;
  - the counter width constant (4 bits).
- Sub-module byte_lane_align (combinational) takes the memory word, offset and width and produces:
  - the sign-extended load value;
  - the merged store word and its 4-bit lane-enable mask.
- The top level holds the FSM, counter, request latches and storage array.

## Test plan
- Word store then load, LATENCY=2: write 0xDEADBEEF to address 0x10, then read 0x10. Expected: Busy high for 3 cycles each time, Done in cycle 3, ReadData=0xDEADBEEF, AddrError=0.
- Byte and half accesses on the word at 0x20 holding 0x80FF7F01:
  - byte read at 0x23 returns 0xFFFFFF80;
  - half read at 0x20 returns 0x00007F01;
  - byte store of 0xAA at 0x21 leaves the word as 0x80FFAA01.
- Rejected requests, each giving Done with AddrError=1, ReadData=0 and no memory change:
  - word read at 0x12;
  - half read at 0x13;
  - address 4*DEPTH_WORDS;
  - MemRead and MemWrite both asserted;
  - DataWidth=11.
- Back-to-back traffic: store at 0x0 then load at 0x0 with the request held while Busy. Expected: the second acceptance in cycle LATENCY+2, and the load returns the just-stored value.
- Reset mid-store: assert Reset during WAIT of a store of 0x12345678 to 0x40, whose prior value is 0x0. Expected: outputs return to reset values and a later read of 0x40 returns 0x0.
- LATENCY=1 build: Busy high for 2 cycles and Done in cycle 2.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_pkg;

    // Width of the access-latency wait counter
    localparam int CNT_W = 4;

    // DataWidth encodings presented by the MEM stage
    typedef enum logic [1:0] {
        DW_WORD    = 2'b00,
        DW_HALF    = 2'b01,
        DW_BYTE    = 2'b10,
        DW_ILLEGAL = 2'b11
    } width_t;

    // Responder FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // A half must sit on an even byte, a word on a multiple of four
    function automatic logic isMisaligned(input width_t width, input logic [1:0] offset);
        return ((width == DW_HALF) && offset[0]) ||
               ((width == DW_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store request bus between the datapath and the responder.
interface data_mem_responder_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [1:0]  DataWidth;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Done;
    logic        AddrError;

    // Datapath side: issues requests, consumes results and the stall
    modport master (
        output MemRead, MemWrite, Address, WriteData, DataWidth,
        input  ReadData, Busy, Done, AddrError
    );

    // Responder side
    modport slave (
        input  MemRead, MemWrite, Address, WriteData, DataWidth,
        output ReadData, Busy, Done, AddrError
    );

endinterface

// File: rtl/data_mem_responder_byte_lane_align.sv
// Little-endian byte-lane steering: extracts sign-extended load data from a
// memory word and builds the merged store word plus its lane-enable mask.
import mem_pkg::*;

module byte_lane_align (
    input  logic [31:0] i_memWord,
    input  logic [1:0]  i_offset,
    input  width_t      i_width,
    input  logic [31:0] i_storeData,
    output logic [31:0] o_loadValue,
    output logic [31:0] o_storeWord,
    output logic [3:0]  o_laneMask
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_repData;

    // Select the addressed lanes, sign-extend loads and replicate store data into every lane
    always_comb begin
        w_half      = i_offset[1] ? i_memWord[31:16] : i_memWord[15:0];
        w_byte      = i_memWord[7:0];
        o_loadValue = '0;
        o_laneMask  = '0;
        w_repData   = i_storeData;
        o_storeWord = i_memWord;

        case (i_offset)
            2'd0:    w_byte = i_memWord[7:0];
            2'd1:    w_byte = i_memWord[15:8];
            2'd2:    w_byte = i_memWord[23:16];
            default: w_byte = i_memWord[31:24];
        endcase

        case (i_width)
            DW_WORD: begin
                o_loadValue = i_memWord;
                o_laneMask  = 4'b1111;
                w_repData   = i_storeData;
            end
            DW_HALF: begin
                o_loadValue = {{16{w_half[15]}}, w_half};
                o_laneMask  = i_offset[1] ? 4'b1100 : 4'b0011;
                w_repData   = {2{i_storeData[15:0]}};
            end
            DW_BYTE: begin
                o_loadValue = {{24{w_byte[7]}}, w_byte};
                o_laneMask  = 4'b0001 << i_offset;
                w_repData   = {4{i_storeData[7:0]}};
            end
            default: begin
                o_loadValue = '0;
                o_laneMask  = '0;
            end
        endcase

        for (int k = 0; k < 4; k++) begin
            o_storeWord[8*k +: 8] = o_laneMask[k] ? w_repData[8*k +: 8] : i_memWord[8*k +: 8];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: accepts a load/store, waits a
// fixed latency while stalling the pipeline, then pulses Done with the result.
import mem_pkg::*;

module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_count;
    logic [AW-1:0]      r_wordIdx;
    logic [1:0]         r_offset;
    width_t             r_width;
    logic [31:0]        r_wdata;
    logic               r_isWrite;
    logic               r_err;
    logic [31:0]        r_readData;
    logic               r_done;
    logic               r_addrErr;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_req;
    logic               w_reqErr;
    logic               w_accept;
    logic               w_finish;
    logic               w_commit;
    logic [31:0]        w_memWord;
    logic [31:0]        w_loadValue;
    logic [31:0]        w_storeWord;
    logic [3:0]         w_laneMask;

    assign w_req = bus.MemRead | bus.MemWrite;

    // Rejection is decided once, at acceptance, from the live request
    assign w_reqErr = (bus.MemRead & bus.MemWrite) |
                      (bus.DataWidth == DW_ILLEGAL) |
                      isMisaligned(width_t'(bus.DataWidth), bus.Address[1:0]) |
                      ({2'b00, bus.Address[31:2]} >= 32'(DEPTH_WORDS));

    assign w_memWord = r_mem[r_wordIdx];
    assign w_commit  = w_finish & r_isWrite & ~r_err;

    byte_lane_align u_align (
        .i_memWord   (w_memWord),
        .i_offset    (r_offset),
        .i_width     (r_width),
        .i_storeData (r_wdata),
        .o_loadValue (w_loadValue),
        .o_storeWord (w_storeWord),
        .o_laneMask  (w_laneMask)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; DONE ignores inputs since the stalled pipeline still shows the old request
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_nextState = S_WAIT;
                    w_accept    = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_count == '0) begin
                    w_nextState = S_DONE;
                    w_finish    = 1'b1;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Request latches, wait counter and registered result outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count    <= '0;
            r_wordIdx  <= '0;
            r_offset   <= '0;
            r_width    <= DW_WORD;
            r_wdata    <= '0;
            r_isWrite  <= 1'b0;
            r_err      <= 1'b0;
            r_readData <= '0;
            r_done     <= 1'b0;
            r_addrErr  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_count   <= CNT_W'(LATENCY - 1);
                r_wordIdx <= bus.Address[AW+1:2];
                r_offset  <= bus.Address[1:0];
                r_width   <= width_t'(bus.DataWidth);
                r_wdata   <= bus.WriteData;
                r_isWrite <= bus.MemWrite;
                r_err     <= w_reqErr;
            end else if ((r_state == S_WAIT) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
            if (w_finish) begin
                r_addrErr  <= r_err;
                r_readData <= (r_err || r_isWrite) ? 32'h0 : w_loadValue;
            end else if (r_state == S_DONE) begin
                r_addrErr <= 1'b0;
            end
        end
    end

    // Storage array, not reset; only the addressed lanes of a store are written
    always_ff @(posedge Clk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_laneMask[k]) begin
                    r_mem[r_wordIdx][8*k +: 8] <= w_storeWord[8*k +: 8];
                end
            end
        end
    end

    assign bus.Busy      = Reset & ((r_state == S_WAIT) | ((r_state == S_IDLE) & w_req));
    assign bus.ReadData  = r_readData;
    assign bus.Done      = r_done;
    assign bus.AddrError = r_addrErr;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized, model-checked bench for data_mem_responder (LATENCY=2 and LATENCY=1 builds).
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic Clk;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] modelMem [DEPTH];

    data_mem_responder_if busA ();
    data_mem_responder_if busB ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dutA (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (busA)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dutB (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (busB)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference rules: rejection condition
    function automatic logic modelErr(input logic rd, input logic wr, input logic [31:0] addr, input logic [1:0] dw);
        if (rd && wr) return 1'b1;
        if (dw == 2'd3) return 1'b1;
        if (dw == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (dw == 2'd0 && (addr % 4) != 0) return 1'b1;
        if ((addr / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int nBytes(input logic [1:0] dw);
        return (dw == 2'd0) ? 4 : (dw == 2'd1) ? 2 : 1;
    endfunction

    // Reference rules: load value with sign extension
    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [1:0] dw);
        logic [31:0] word;
        logic [31:0] val;
        int n;
        int off;
        word = modelMem[addr / 4];
        n    = nBytes(dw);
        off  = int'(addr % 4);
        if (n == 4) return word;
        val = (word >> (8 * off)) & ((32'h1 << (8 * n)) - 1);
        if (val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 1);
        return val;
    endfunction

    // Reference rules: store touches only the addressed bytes
    function automatic void modelStore(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] dw);
        logic [31:0] word;
        logic [31:0] b;
        int lane;
        word = modelMem[addr / 4];
        for (int k = 0; k < nBytes(dw); k++) begin
            lane = int'(addr % 4) + k;
            b    = (data >> (8 * k)) & 32'hFF;
            word = (word & ~(32'hFF << (8 * lane))) | (b << (8 * lane));
        end
        modelMem[addr / 4] = word;
    endfunction

    // Issue one request just after a rising edge and hold it until Done (bounded)
    task automatic access(input bit which, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] dw,
                          output logic [31:0] rdata, output logic err, output int busyCnt, output int doneCyc);
        logic b;
        logic d;
        @(posedge Clk);
        #1;
        if (which) begin
            busB.MemRead = rd; busB.MemWrite = wr; busB.Address = addr;
            busB.WriteData = wdata; busB.DataWidth = dw;
        end else begin
            busA.MemRead = rd; busA.MemWrite = wr; busA.Address = addr;
            busA.WriteData = wdata; busA.DataWidth = dw;
        end
        busyCnt = 0;
        doneCyc = -1;
        rdata   = 32'h0;
        err     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            b = which ? busB.Busy : busA.Busy;
            d = which ? busB.Done : busA.Done;
            if (b) busyCnt++;
            if (d) begin
                doneCyc = c;
                rdata   = which ? busB.ReadData : busA.ReadData;
                err     = which ? busB.AddrError : busA.AddrError;
                break;
            end
        end
    endtask

    task automatic goIdle();
        @(posedge Clk);
        #1;
        busA.MemRead = 1'b0; busA.MemWrite = 1'b0;
        busB.MemRead = 1'b0; busB.MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        busA.MemRead = 1'b1; busA.MemWrite = 1'b0; busA.Address = 32'h0;
        busA.WriteData = 32'h0; busA.DataWidth = 2'd0;
        busB.MemRead = 1'b0; busB.MemWrite = 1'b0; busB.Address = 32'h0;
        busB.WriteData = 32'h0; busB.DataWidth = 2'd0;
        repeat (3) @(negedge Clk);
        checks++; if (busA.Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busA.Busy); end
        checks++; if (busA.Done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", busA.Done); end
        checks++; if (busA.AddrError !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", busA.AddrError); end
        checks++; if (busA.ReadData !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", busA.ReadData); end
        checks++; if (busB.Done !== 1'b0) begin failures++; $display("[TB] FAIL resetB_done: got %b expected 0", busB.Done); end
        busA.MemRead = 1'b0;
        Reset = 1'b1;
    endtask

    // Give the low 64 words known contents so random traffic can be predicted
    task automatic test_init();
        logic [31:0] rdata;
        logic err;
        int bc;
        int dc;
        logic [31:0] v;
        int bad = 0;
        for (int w = 0; w < 64; w++) begin
            v = $urandom;
            access(1'b0, 1'b0, 1'b1, 32'(w * 4), v, 2'd0, rdata, err, bc, dc);
            modelStore(32'(w * 4), v, 2'd0);
            if (err !== 1'b0 || dc != LAT_A + 1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL init_stores: got %0d bad stores expected 0", bad); end
    endtask

    task automatic test_word();
        logic [31:0] rdata;
        logic err;
        int bc;
        int dc;
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd0, rdata, err, bc, dc);
        modelStore(32'h10, 32'hDEADBEEF, 2'd0);
        checks++; if (bc != LAT_A + 1) begin failures++; $display("[TB] FAIL word_store_busy: got %0d expected %0d", bc, LAT_A + 1); end
        checks++; if (dc != LAT_A + 1) begin failures++; $display("[TB] FAIL word_store_done: got %0d expected %0d", dc, LAT_A + 1); end
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd0, rdata, err, bc, dc);
        checks++; if (bc != LAT_A + 1) begin failures++; $display("[TB] FAIL word_load_busy: got %0d expected %0d", bc, LAT_A + 1); end
        checks++; if (dc != LAT_A + 1) begin failures++; $display("[TB] FAIL word_load_done: got %0d expected %0d", dc, LAT_A + 1); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL word_load_data: got %h expected deadbeef", rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL word_load_err: got %b expected 0", err); end
        goIdle();
    endtask

    task automatic test_narrow();
        logic [31:0] rdata;
        logic err;
        int bc;
        int dc;
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'h80FF7F01, 2'd0, rdata, err, bc, dc);
        modelStore(32'h20, 32'h80FF7F01, 2'd0);
        access(1'b0, 1'b1, 1'b0, 32'h23, 32'h0, 2'd2, rdata, err, bc, dc);
        checks++; if (rdata !== 32'hFFFFFF80) begin failures++; $display("[TB] FAIL byte_load_0x23: got %h expected ffffff80", rdata); end
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd1, rdata, err, bc, dc);
        checks++; if (rdata !== 32'h00007F01) begin failures++; $display("[TB] FAIL half_load_0x20: got %h expected 00007f01", rdata); end
        access(1'b0, 1'b1, 1'b0, 32'h22, 32'h0, 2'd1, rdata, err, bc, dc);
        checks++; if (rdata !== 32'hFFFF80FF) begin failures++; $display("[TB] FAIL half_load_0x22: got %h expected ffff80ff", rdata); end
        access(1'b0, 1'b0, 1'b1, 32'h21, 32'h123456AA, 2'd2, rdata, err, bc, dc);
        modelStore(32'h21, 32'h123456AA, 2'd2);
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd0, rdata, err, bc, dc);
        checks++; if (rdata !== 32'h80FFAA01) begin failures++; $display("[TB] FAIL byte_store_0x21: got %h expected 80ffaa01", rdata); end
        goIdle();
    endtask

    task automatic test_errors();
        logic [31:0] rdata;
        logic err;
        int bc;
        int dc;
        logic        rdT [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        wrT [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] adT [5] = '{32'h12, 32'h13, 32'(4 * DEPTH), 32'h10, 32'h10};
        logic [1:0]  dwT [5] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd3};
        for (int i = 0; i < 5; i++) begin
            access(1'b0, rdT[i], wrT[i], adT[i], 32'h11111111, dwT[i], rdata, err, bc, dc);
            checks++; if (err !== 1'b1 || dc != LAT_A + 1) begin failures++; $display("[TB] FAIL reject_%0d_err: got err=%b done=%0d expected err=1 done=%0d", i, err, dc, LAT_A + 1); end
            checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL reject_%0d_rdata: got %h expected 0", i, rdata); end
        end
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd0, rdata, err, bc, dc);
        checks++; if (rdata !== modelMem[4]) begin failures++; $display("[TB] FAIL reject_no_write: got %h expected %h", rdata, modelMem[4]); end
        goIdle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdata;
        logic err;
        int bc;
        int dc;
        logic [31:0] v;
        v = $urandom;
        access(1'b0, 1'b0, 1'b1, 32'h0, v, 2'd0, rdata, err, bc, dc);
        modelStore(32'h0, v, 2'd0);
        access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 2'd0, rdata, err, bc, dc);
        checks++; if (dc != LAT_A + 1) begin failures++; $display("[TB] FAIL b2b_second_done: got %0d expected %0d", dc, LAT_A + 1); end
        checks++; if (rdata !== v) begin failures++; $display("[TB] FAIL b2b_load_data: got %h expected %h", rdata, v); end
    endtask

    task automatic test_random();
        logic [31:0] rdata;
        logic err;
        int bc;
        int dc;
        logic rd;
        logic wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0] dw;
        logic expErr;
        logic [31:0] expData;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       begin rd = 1'b1; wr = 1'b1; end
                1, 2, 3: begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            addr  = ($urandom_range(0, 15) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 255)) : 32'($urandom_range(0, 255));
            wdata = $urandom;
            dw    = 2'($urandom_range(0, 3));
            expErr  = modelErr(rd, wr, addr, dw);
            expData = (expErr || wr) ? 32'h0 : modelLoad(addr, dw);
            access(1'b0, rd, wr, addr, wdata, dw, rdata, err, bc, dc);
            if (!expErr && wr) modelStore(addr, wdata, dw);
            checks++; if (err !== expErr || dc != LAT_A + 1 || bc != LAT_A + 1) begin failures++; $display("[TB] FAIL rand_%0d_status: got err=%b done=%0d busy=%0d expected err=%b done=%0d busy=%0d", i, err, dc, bc, expErr, LAT_A + 1, LAT_A + 1); end
            if (rd || expErr) begin
                checks++; if (rdata !== expData) begin failures++; $display("[TB] FAIL rand_%0d_rdata addr=%h dw=%0d: got %h expected %h", i, addr, dw, rdata, expData); end
            end
        end
        goIdle();
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rdata;
        logic err;
        int bc;
        int dc;
        access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 2'd0, rdata, err, bc, dc);
        modelStore(32'h40, 32'h0, 2'd0);
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd0, rdata, err, bc, dc);
        @(posedge Clk);
        #1;
        busA.MemRead = 1'b0; busA.MemWrite = 1'b1; busA.Address = 32'h40;
        busA.WriteData = 32'h12345678; busA.DataWidth = 2'd0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++; if (busA.Busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busA.Busy); end
        checks++; if (busA.Done !== 1'b0 || busA.AddrError !== 1'b0) begin failures++; $display("[TB] FAIL midrst_flags: got done=%b err=%b expected 0 0", busA.Done, busA.AddrError); end
        checks++; if (busA.ReadData !== 32'h0) begin failures++; $display("[TB] FAIL midrst_rdata: got %h expected 0", busA.ReadData); end
        busA.MemWrite = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 2'd0, rdata, err, bc, dc);
        checks++; if (rdata !== 32'h0 || dc != LAT_A + 1) begin failures++; $display("[TB] FAIL midrst_dropped: got %h done=%0d expected 0 done=%0d", rdata, dc, LAT_A + 1); end
        goIdle();
    endtask

    task automatic test_latency1();
        logic [31:0] rdata;
        logic err;
        int bc;
        int dc;
        access(1'b1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 2'd0, rdata, err, bc, dc);
        checks++; if (bc != LAT_B + 1 || dc != LAT_B + 1) begin failures++; $display("[TB] FAIL lat1_store_timing: got busy=%0d done=%0d expected %0d %0d", bc, dc, LAT_B + 1, LAT_B + 1); end
        access(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 2'd1, rdata, err, bc, dc);
        checks++; if (bc != LAT_B + 1 || dc != LAT_B + 1) begin failures++; $display("[TB] FAIL lat1_load_timing: got busy=%0d done=%0d expected %0d %0d", bc, dc, LAT_B + 1, LAT_B + 1); end
        checks++; if (rdata !== 32'hFFFFCAFE || err !== 1'b0) begin failures++; $display("[TB] FAIL lat1_load_data: got %h err=%b expected ffffcafe err=0", rdata, err); end
        goIdle();
    endtask

    initial begin
        test_reset();
        test_init();
        test_word();
        test_narrow();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid_store();
        test_latency1();
        repeat (2) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
